// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter slice.
// The optional grant statistics are enabled with the RAM_ARB_STATS_EN macro.
package ram_arb_pkg;

  // Sequencer states: one RAM access every three cycles.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  // Requester index (two ports).
  typedef logic port_idx_t;

  // Width of the optional per-port grant counters.
  localparam int unsigned STATS_W = 16;

  // Saturating increment used by the grant counters.
  function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/ram_arb_rr2.sv
// Combinational two-way round-robin pick.
// A lone requester always wins; on a tie the port that was not granted
// last time wins.
module ram_arb_rr2
  import ram_arb_pkg::*;
(
  input  logic      req0,
  input  logic      req1,
  input  port_idx_t last_gnt,
  output logic      valid,
  output port_idx_t winner
);

  // Pick a winner from the current requests and the previous grant.
  always_comb begin
    valid  = req0 | req1;
    winner = 1'b0;
    if (req0 && req1) begin
      winner = ~last_gnt;
    end else if (req1) begin
      winner = 1'b1;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Two-requester round-robin arbiter/sequencer in front of a single-port
// synchronous RAM (sync write, combinational read gated by rd && cs).
// Flow per access: IDLE (arbitrate) -> ACCESS (drive RAM) -> RESP (ack).
// Define RAM_ARB_STATS_EN to add saturating per-port grant counters
// (gnt_cnt0 / gnt_cnt1).
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_SIZE = 2,
  parameter int DATA_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0,
  input  logic                 we0,
  input  logic [ADDR_SIZE-1:0] addr0,
  input  logic [DATA_SIZE-1:0] wdata0,
  output logic                 ack0,
  output logic [DATA_SIZE-1:0] rdata0,
  input  logic                 req1,
  input  logic                 we1,
  input  logic [ADDR_SIZE-1:0] addr1,
  input  logic [DATA_SIZE-1:0] wdata1,
  output logic                 ack1,
  output logic [DATA_SIZE-1:0] rdata1,
  output logic                 ram_cs,
  output logic                 ram_rd,
  output logic                 ram_we,
  output logic [ADDR_SIZE-1:0] ram_addr,
  output logic [DATA_SIZE-1:0] ram_wdata,
  input  logic [DATA_SIZE-1:0] ram_rdata,
  output logic                 busy
`ifdef RAM_ARB_STATS_EN
  ,
  output logic [STATS_W-1:0]   gnt_cnt0,
  output logic [STATS_W-1:0]   gnt_cnt1
`endif
);

  arb_state_t           state;
  port_idx_t            last_gnt;
  port_idx_t            cap_port;
  logic                 pick_valid;
  port_idx_t            pick;
  logic                 sel_we;
  logic [ADDR_SIZE-1:0] sel_addr;
  logic [DATA_SIZE-1:0] sel_wdata;

  ram_arb_rr2 u_rr2 (
    .req0     (req0),
    .req1     (req1),
    .last_gnt (last_gnt),
    .valid    (pick_valid),
    .winner   (pick)
  );

  // Route the winning requester's command fields toward the capture regs.
  always_comb begin
    sel_we    = we0;
    sel_addr  = addr0;
    sel_wdata = wdata0;
    if (pick) begin
      sel_we    = we1;
      sel_addr  = addr1;
      sel_wdata = wdata1;
    end
  end

  // Sequencer: the RAM command registers double as the captured request,
  // so ACCESS drives them straight from flops with no extra stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      last_gnt  <= 1'b1;
      cap_port  <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
      ram_cs    <= 1'b0;
      ram_rd    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ack0 <= 1'b0;
          ack1 <= 1'b0;
          if (pick_valid) begin
            state     <= ACCESS;
            last_gnt  <= pick;
            cap_port  <= pick;
            busy      <= 1'b1;
            ram_cs    <= 1'b1;
            ram_we    <= sel_we;
            ram_rd    <= ~sel_we;
            ram_addr  <= sel_addr;
            ram_wdata <= sel_we ? sel_wdata : '0;
          end
        end
        ACCESS: begin
          state <= RESP;
          if (ram_rd) begin
            if (cap_port) rdata1 <= ram_rdata;
            else          rdata0 <= ram_rdata;
          end
          if (cap_port) ack1 <= 1'b1;
          else          ack0 <= 1'b1;
          ram_cs    <= 1'b0;
          ram_rd    <= 1'b0;
          ram_we    <= 1'b0;
          ram_addr  <= '0;
          ram_wdata <= '0;
        end
        RESP: begin
          state <= IDLE;
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef RAM_ARB_STATS_EN
  // Count grants per port on every entry to ACCESS, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
    end else if (state == IDLE && pick_valid) begin
      if (pick) gnt_cnt1 <= sat_inc(gnt_cnt1);
      else      gnt_cnt0 <= sat_inc(gnt_cnt0);
    end
  end
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed self-checking bench for ram_port_arbiter with a behavioural RAM.
// Define RAM_ARB_STATS_EN to also exercise the grant counters.
module tb_ram_port_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [1:0] addr0 = '0, addr1 = '0;
  logic [7:0] wdata0 = '0, wdata1 = '0;
  logic       ack0, ack1;
  logic [7:0] rdata0, rdata1;
  logic       ram_cs, ram_rd, ram_we;
  logic [1:0] ram_addr;
  logic [7:0] ram_wdata, ram_rdata;
  logic       busy;
`ifdef RAM_ARB_STATS_EN
  logic [15:0] gnt_cnt0, gnt_cnt1;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic [7:0] mem [4];

  always #5 clk = ~clk;

  // Behavioural RAM: sync write, combinational gated read; reset preloads it.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem[0] <= 8'h11;
      mem[1] <= 8'h22;
      mem[2] <= 8'h33;
      mem[3] <= 8'h44;
    end else if (ram_cs && ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
  end

  assign ram_rdata = (ram_cs && ram_rd) ? mem[ram_addr] : 8'h00;

  ram_port_arbiter #(.ADDR_SIZE(2), .DATA_SIZE(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .req0      (req0),
    .we0       (we0),
    .addr0     (addr0),
    .wdata0    (wdata0),
    .ack0      (ack0),
    .rdata0    (rdata0),
    .req1      (req1),
    .we1       (we1),
    .addr1     (addr1),
    .wdata1    (wdata1),
    .ack1      (ack1),
    .rdata1    (rdata1),
    .ram_cs    (ram_cs),
    .ram_rd    (ram_rd),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
`ifdef RAM_ARB_STATS_EN
    .gnt_cnt0  (gnt_cnt0),
    .gnt_cnt1  (gnt_cnt1),
`endif
    .busy      (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    n_cmp++;
    if ({ack0, ack1, busy} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_ctl: got ack0/ack1/busy=%b want 000", {ack0, ack1, busy});
    end
    n_cmp++;
    if ({rdata0, rdata1} !== 16'h0000) begin
      n_err++;
      $display("FAIL reset_rdata: got %h want 0000", {rdata0, rdata1});
    end
    n_cmp++;
    if ({ram_cs, ram_rd, ram_we, ram_addr, ram_wdata} !== 13'h0) begin
      n_err++;
      $display("FAIL reset_ram: got %h want 0", {ram_cs, ram_rd, ram_we, ram_addr, ram_wdata});
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_write_read();
    req0 = 1'b1; we0 = 1'b1; addr0 = 2'd2; wdata0 = 8'hA5;
    step();  // ACCESS
    n_cmp++;
    if ({ram_cs, ram_we, ram_rd, ram_addr, ram_wdata, busy, ack0} !== {3'b110, 2'd2, 8'hA5, 2'b10}) begin
      n_err++;
      $display("FAIL wr_access: got cs/we/rd/addr/wd/busy/ack0=%b%b%b %0d %h %b%b want 110 2 a5 10",
               ram_cs, ram_we, ram_rd, ram_addr, ram_wdata, busy, ack0);
    end
    step();  // RESP
    n_cmp++;
    if ({ack0, ack1, ram_cs, ram_we, busy} !== 5'b10001) begin
      n_err++;
      $display("FAIL wr_resp: got ack0/ack1/cs/we/busy=%b want 10001", {ack0, ack1, ram_cs, ram_we, busy});
    end
    req0 = 1'b0;
    step();  // IDLE
    n_cmp++;
    if ({ack0, busy} !== 2'b00) begin
      n_err++;
      $display("FAIL wr_idle: got ack0/busy=%b want 00", {ack0, busy});
    end
    req1 = 1'b1; we1 = 1'b0; addr1 = 2'd2;
    step();  // ACCESS
    n_cmp++;
    if ({ram_cs, ram_rd, ram_we, ram_addr} !== {3'b110, 2'd2}) begin
      n_err++;
      $display("FAIL rd_access: got cs/rd/we/addr=%b%b%b %0d want 110 2", ram_cs, ram_rd, ram_we, ram_addr);
    end
    step();  // RESP
    n_cmp++;
    if ({ack1, ack0, rdata1} !== {2'b10, 8'hA5}) begin
      n_err++;
      $display("FAIL rd_resp: got ack1/ack0=%b%b rdata1=%h want 10 a5", ack1, ack0, rdata1);
    end
    req1 = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_ack;
    logic [1:0] exp_addr;
    req0 = 1'b1; we0 = 1'b0; addr0 = 2'd3;
    req1 = 1'b1; we1 = 1'b0; addr1 = 2'd0;
    for (int unsigned g = 0; g < 4; g++) begin
      exp_ack  = (g % 2 == 0) ? 2'b01 : 2'b10;  // {ack1, ack0}
      exp_addr = (g % 2 == 0) ? 2'd3 : 2'd0;
      step();  // ACCESS
      n_cmp++;
      if ({ram_cs, ram_rd, ram_addr, ack1, ack0} !== {2'b11, exp_addr, 2'b00}) begin
        n_err++;
        $display("FAIL rr_access%0d: got cs/rd=%b%b addr=%0d acks=%b%b want 11 %0d 00",
                 g, ram_cs, ram_rd, ram_addr, ack1, ack0, exp_addr);
      end
      step();  // RESP
      n_cmp++;
      if ({ack1, ack0} !== exp_ack) begin
        n_err++;
        $display("FAIL rr_grant%0d: got ack1/ack0=%b%b want %b", g, ack1, ack0, exp_ack);
      end
      n_cmp++;
      if ((g % 2 == 0 && rdata0 !== 8'h44) || (g % 2 == 1 && rdata1 !== 8'h11)) begin
        n_err++;
        $display("FAIL rr_rdata%0d: got rdata0=%h rdata1=%h want port%0d data %h",
                 g, rdata0, rdata1, g % 2, (g % 2 == 0) ? 8'h44 : 8'h11);
      end
      if (g == 3) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
      step();  // IDLE
      n_cmp++;
      if ({ack1, ack0, busy} !== 3'b000) begin
        n_err++;
        $display("FAIL rr_idle%0d: got ack1/ack0/busy=%b want 000", g, {ack1, ack0, busy});
      end
    end
  endtask

  task automatic test_write_then_read();
    req1 = 1'b1; we1 = 1'b1; addr1 = 2'd1; wdata1 = 8'h3C;
    step();  // port 1 ACCESS
    n_cmp++;
    if ({ram_we, ram_addr, ram_wdata} !== {1'b1, 2'd1, 8'h3C}) begin
      n_err++;
      $display("FAIL wtr_write: got we=%b addr=%0d wd=%h want 1 1 3c", ram_we, ram_addr, ram_wdata);
    end
    req0 = 1'b1; we0 = 1'b0; addr0 = 2'd1;
    step();  // port 1 RESP
    n_cmp++;
    if ({ack1, ack0, rdata1} !== {2'b10, 8'h11}) begin
      n_err++;
      $display("FAIL wtr_ack1: got ack1/ack0=%b%b rdata1=%h want 10 11", ack1, ack0, rdata1);
    end
    req1 = 1'b0;
    step();  // IDLE
    step();  // port 0 ACCESS
    n_cmp++;
    if ({ram_rd, ram_addr} !== {1'b1, 2'd1}) begin
      n_err++;
      $display("FAIL wtr_read: got rd=%b addr=%0d want 1 1", ram_rd, ram_addr);
    end
    step();  // port 0 RESP
    n_cmp++;
    if ({ack0, ack1, rdata0, rdata1} !== {2'b10, 8'h3C, 8'h11}) begin
      n_err++;
      $display("FAIL wtr_ack0: got ack0/ack1=%b%b rdata0=%h rdata1=%h want 10 3c 11",
               ack0, ack1, rdata0, rdata1);
    end
    req0 = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    req0 = 1'b1; we0 = 1'b1; addr0 = 2'd3; wdata0 = 8'hFF;
    step();  // ACCESS
    n_cmp++;
    if ({ram_cs, ram_we, ram_addr} !== {2'b11, 2'd3}) begin
      n_err++;
      $display("FAIL rst_mid_access: got cs/we=%b%b addr=%0d want 11 3", ram_cs, ram_we, ram_addr);
    end
    reset = 1'b1;
    req0 = 1'b0;
    step();
    n_cmp++;
    if ({ack0, busy, ram_cs, ram_rd, ram_we, ram_addr, ram_wdata} !== 15'h0) begin
      n_err++;
      $display("FAIL rst_mid_outputs: got ack0=%b busy=%b cs/rd/we=%b%b%b addr=%0d wd=%h want all 0",
               ack0, busy, ram_cs, ram_rd, ram_we, ram_addr, ram_wdata);
    end
    reset = 1'b0;
    step();
    n_cmp++;
    if ({ack0, busy, rdata0} !== 10'h0) begin
      n_err++;
      $display("FAIL rst_mid_after: got ack0=%b busy=%b rdata0=%h want 0 0 00", ack0, busy, rdata0);
    end
    req1 = 1'b1; we1 = 1'b0; addr1 = 2'd0;
    step();  // ACCESS
    n_cmp++;
    if ({ram_cs, ram_rd, ram_addr} !== {2'b11, 2'd0}) begin
      n_err++;
      $display("FAIL rst_mid_req1_access: got cs/rd=%b%b addr=%0d want 11 0", ram_cs, ram_rd, ram_addr);
    end
    step();  // RESP
    n_cmp++;
    if ({ack1, ack0, rdata1} !== {2'b10, 8'h11}) begin
      n_err++;
      $display("FAIL rst_mid_req1_resp: got ack1/ack0=%b%b rdata1=%h want 10 11", ack1, ack0, rdata1);
    end
    req1 = 1'b0;
    step();
  endtask

  task automatic test_idle();
    for (int unsigned c = 0; c < 10; c++) begin
      step();
      n_cmp++;
      if ({ram_cs, busy, ack0, ack1} !== 4'b0000) begin
        n_err++;
        $display("FAIL idle%0d: got cs/busy/ack0/ack1=%b want 0000", c, {ram_cs, busy, ack0, ack1});
      end
    end
  endtask

`ifdef RAM_ARB_STATS_EN
  task automatic test_stats();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    for (int unsigned k = 0; k < 8; k++) begin
      if (k < 5) begin
        req0 = 1'b1; we0 = 1'b0; addr0 = 2'd0;
      end else begin
        req1 = 1'b1; we1 = 1'b0; addr1 = 2'd1;
      end
      step();
      step();
      req0 = 1'b0;
      req1 = 1'b0;
      step();
    end
    n_cmp++;
    if ({gnt_cnt0, gnt_cnt1} !== {16'd5, 16'd3}) begin
      n_err++;
      $display("FAIL stats_count: got %0d/%0d want 5/3", gnt_cnt0, gnt_cnt1);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_cmp++;
    if ({gnt_cnt0, gnt_cnt1} !== 32'h0) begin
      n_err++;
      $display("FAIL stats_reset: got %0d/%0d want 0/0", gnt_cnt0, gnt_cnt1);
    end
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_write_then_read();
    test_reset_mid();
    test_idle();
`ifdef RAM_ARB_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
